// File: rtl/fifo_stream_reader.sv
// Read-side adapter for a registered-read FIFO. It prefetches into a 2-entry
// buffer and presents the beats as a valid/ready stream, in FIFO order.
module fifo_stream_reader #(
  parameter type T = logic [31:0]
) (
  input  logic       clk,
  input  logic       reset,
  output logic       fifo_read_en,
  input  T           fifo_read_data,
  input  logic       fifo_empty,
  input  logic       flush,
  output logic       out_valid,
  output T           out_data,
  input  logic       out_ready,
  output logic [1:0] occupancy
);

  localparam int unsigned DEPTH = 2;
  localparam int unsigned LVL_W = 3;

  T                 mem_q [DEPTH];
  T                 mem_n [DEPTH];
  logic             head_q;
  logic             head_n;
  logic             tail_q;
  logic             tail_n;
  logic [1:0]       held_q;
  logic [1:0]       held_n;
  logic             inflight_q;
  logic             pop;
  logic [LVL_W-1:0] level;
  T                 out_data_n;

  // Entries committed after this cycle (held + in-flight - pop) bound the read strobe.
  always_comb begin
    pop          = out_valid & out_ready;
    level        = LVL_W'(held_q) + LVL_W'(inflight_q) - LVL_W'(pop);
    fifo_read_en = ~reset & ~flush & ~fifo_empty & (level < LVL_W'(DEPTH));

    mem_n  = mem_q;
    head_n = head_q;
    tail_n = tail_q;
    held_n = level[1:0];

    if (pop) begin
      head_n = ~head_q;
    end
    if (inflight_q) begin
      mem_n[tail_q] = fifo_read_data;
      tail_n        = ~tail_q;
    end
    // Flush drops held entries and the beat arriving this cycle.
    if (flush) begin
      held_n = 2'd0;
      head_n = 1'b0;
      tail_n = 1'b0;
    end

    out_data_n = mem_n[head_n];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q      <= '{default: '0};
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      held_q     <= 2'd0;
      inflight_q <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
    end else begin
      mem_q      <= mem_n;
      head_q     <= head_n;
      tail_q     <= tail_n;
      held_q     <= held_n;
      inflight_q <= fifo_read_en;
      out_valid  <= (held_n != 2'd0);
      out_data   <= out_data_n;
    end
  end

  assign occupancy = held_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: FIFO model plus a queue-based scoreboard of
// read-but-not-yet-delivered beats, driven by tables, hand sequences and random traffic.
module tb_fifo_stream_reader;

  typedef logic [31:0] data_t;

  typedef struct {
    int unsigned nbeats;
    int unsigned stall;
    int unsigned exp_reads;
    logic [1:0]  exp_occ;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       fifo_read_en;
  data_t      fifo_read_data = '0;
  logic       fifo_empty;
  logic       flush;
  logic       out_valid;
  data_t      out_data;
  logic       out_ready;
  logic [1:0] occupancy;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned n_reads = 0;
  int unsigned n_pops = 0;
  logic        last_read = 1'b0;

  data_t fq[$];     // contents of the upstream FIFO
  data_t exp_q[$];  // beats read from the FIFO and not yet delivered, oldest first

  always #5 clk = ~clk;

  fifo_stream_reader #(.T(data_t)) dut (
    .clk            (clk),
    .reset          (reset),
    .fifo_read_en   (fifo_read_en),
    .fifo_read_data (fifo_read_data),
    .fifo_empty     (fifo_empty),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_ready      (out_ready),
    .occupancy      (occupancy)
  );

  task automatic chk(input string name, input data_t act, input data_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input data_t v);
    fq.push_back(v);
    fifo_empty = 1'b0;
  endtask

  // Negedge: compare outputs with the scoreboard, then account for this cycle's pop/flush/read.
  task automatic sample();
    int   exp_occ;
    logic exp_rd;
    @(negedge clk);
    if (reset) begin
      chk("reset_read_en", 32'(fifo_read_en), 32'd0);
      exp_q.delete();
      last_read = 1'b0;
      return;
    end
    exp_occ = int'(exp_q.size()) - (last_read ? 1 : 0);
    chk("occupancy", 32'(occupancy), 32'(exp_occ));
    chk("out_valid", 32'(out_valid), 32'(exp_occ != 0));
    if (exp_occ > 0) chk("head_data", out_data, exp_q[0]);
    if (out_valid && out_ready) begin
      n_pops++;
      chk("pop_has_beat", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("pop_data", out_data, exp_q.pop_front());
    end
    if (flush) exp_q.delete();
    exp_rd = !flush && (fq.size() != 0) && (exp_q.size() < 2);
    chk("read_en", 32'(fifo_read_en), 32'(exp_rd));
    if (fifo_read_en) begin
      n_reads++;
      if (fq.size() != 0) exp_q.push_back(fq[0]);
    end
    last_read = fifo_read_en;
  endtask

  // Posedge: registered FIFO read port, then inputs may change 1 time unit later.
  task automatic advance();
    @(posedge clk);
    if (fifo_read_en && fq.size() != 0) fifo_read_data <= fq.pop_front();
    #1;
    fifo_empty = (fq.size() == 0);
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (fq.size() == 0 && exp_q.size() == 0 && !out_valid) begin
        done = 1'b1;
        break;
      end
      step();
    end
    chk("drain_done", 32'(done), 32'd1);
  endtask

  vec_t        vecs[4];
  int unsigned r0;
  int unsigned p0;

  initial begin
    vecs[0] = '{nbeats: 4, stall: 6, exp_reads: 2, exp_occ: 2'd2};
    vecs[1] = '{nbeats: 1, stall: 5, exp_reads: 1, exp_occ: 2'd1};
    vecs[2] = '{nbeats: 3, stall: 6, exp_reads: 2, exp_occ: 2'd2};
    vecs[3] = '{nbeats: 2, stall: 4, exp_reads: 2, exp_occ: 2'd2};

    reset      = 1'b1;
    flush      = 1'b0;
    out_ready  = 1'b0;
    fifo_empty = 1'b1;
    advance();
    advance();

    // Reset held with a non-empty FIFO: nothing is read or presented.
    for (int i = 0; i < 8; i++) push(32'hA0 + 32'(i));
    for (int i = 0; i < 2; i++) begin
      sample();
      chk("t1_read_en", 32'(fifo_read_en), 32'd0);
      chk("t1_out_valid", 32'(out_valid), 32'd0);
      chk("t1_occupancy", 32'(occupancy), 32'd0);
      advance();
    end

    // Streaming at full rate: reads on cycles 0..7, beats on cycles 2..9.
    reset     = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      sample();
      chk("t2_read_en", 32'(fifo_read_en), 32'(k < 8));
      chk("t2_out_valid", 32'(out_valid), 32'(k >= 2 && k < 10));
      if (k >= 2 && k < 10) chk("t2_out_data", out_data, 32'hA0 + 32'(k - 2));
      advance();
    end
    chk("t2_reads", 32'(n_reads), 32'd8);
    drain();

    // Backpressure table: reads stop once two beats are buffered, then drain gap-free.
    for (int v = 0; v < 4; v++) begin
      out_ready = 1'b0;
      r0 = n_reads;
      p0 = n_pops;
      for (int i = 0; i < int'(vecs[v].nbeats); i++) push(32'h100 * 32'(v + 1) + 32'(i));
      for (int s = 0; s < int'(vecs[v].stall); s++) begin
        sample();
        if (s == int'(vecs[v].stall) - 1) begin
          chk("tbl_reads", 32'(n_reads - r0), 32'(vecs[v].exp_reads));
          chk("tbl_occupancy", 32'(occupancy), 32'(vecs[v].exp_occ));
          chk("tbl_head", out_data, 32'h100 * 32'(v + 1));
        end
        advance();
      end
      out_ready = 1'b1;
      for (int k = 0; k < int'(vecs[v].nbeats); k++) begin
        sample();
        chk("tbl_no_gap", 32'(out_valid), 32'd1);
        advance();
      end
      drain();
      chk("tbl_pops", 32'(n_pops - p0), 32'(vecs[v].nbeats));
    end

    // Alternating ready over 16 beats.
    p0 = n_pops;
    for (int i = 0; i < 16; i++) push(32'hC00 + 32'(i));
    for (int c = 0; c < 200 && (n_pops - p0) < 16; c++) begin
      out_ready = c[0];
      step();
    end
    drain();
    chk("t4_pops", 32'(n_pops - p0), 32'd16);

    // Flush with one beat held and one in flight: the in-flight beat is lost.
    p0 = n_pops;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) push(32'hB0 + 32'(i));
    step();
    step();
    step();
    flush = 1'b1;
    sample();
    chk("t5_pre_occupancy", 32'(occupancy), 32'd1);
    chk("t5_flush_read_en", 32'(fifo_read_en), 32'd0);
    advance();
    flush = 1'b0;
    sample();
    chk("t5_post_valid", 32'(out_valid), 32'd0);
    advance();
    drain();
    chk("t5_pops", 32'(n_pops - p0), 32'd9);

    // Empty FIFO with a ready consumer stays idle.
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      sample();
      chk("t6_read_en", 32'(fifo_read_en), 32'd0);
      chk("t6_out_valid", 32'(out_valid), 32'd0);
      advance();
    end

    // Random traffic with occasional flush and reset.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(3) == 0 && fq.size() < 8) push($urandom);
      out_ready = ($urandom_range(2) != 0);
      flush     = ($urandom_range(39) == 0);
      reset     = ($urandom_range(299) == 0);
      if (reset) out_ready = 1'b0;
      step();
    end
    flush = 1'b0;
    reset = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
